// File: rtl/urv_mem2wb_burst_pkg.sv
// Shared types and defaults for the mem-to-Wishbone burst bridge.
// Holds bridge config defaults, CTI encodings and FSM states.
package urv_mem2wb_burst_pkg;

    // urv_cfg defaults
    localparam int URV_MAX_BURST = 8;
    localparam int URV_TMO_CYC   = 255;

    // urv_typedef
    typedef enum logic [2:0] {
        WB_CTI_CLASSIC = 3'b000,
        WB_CTI_INCR    = 3'b010,
        WB_CTI_EOB     = 3'b111
    } wb_cti_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } bridge_state_e;

    function automatic wb_cti_e cti_sel(input logic single,
                                        input logic last);
        if (single)
            return WB_CTI_CLASSIC;
        if (last)
            return WB_CTI_EOB;
        return WB_CTI_INCR;
    endfunction

endpackage

// File: rtl/urv_wb_tmo.sv
// Wishbone wait-state watchdog for the burst bridge.
// Flags the TMO_CYC-th consecutive unanswered strobe cycle.
module urv_wb_tmo #(
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int LAST_I = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam bit ENA = (TMO_CYC != 0);

    logic [CW-1:0] cnt_q;

    // count unanswered strobe cycles, saturating at the trip point
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt_q <= '0;
        else if (en && cnt_q != LAST)
            cnt_q <= cnt_q + 1'b1;
    end

    assign expired = ENA && en && (cnt_q == LAST);

endmodule

// File: rtl/urv_mem2wb_burst.sv
// Burst bridge from the uRV sys bus to Wishbone B4.
// Maps incrementing bursts to registered-feedback CTI cycles.
module urv_mem2wb_burst
    import urv_mem2wb_burst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MASK_W    = DATA_W / 8,
    parameter int MAX_BURST = URV_MAX_BURST,
    parameter int LEN_W     = $clog2(MAX_BURST),
    parameter int TMO_CYC   = URV_TMO_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DATA_W-1:0] wdat_data,
    input  logic [MASK_W-1:0] wdat_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              resp_last,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [MASK_W-1:0] wb_sel_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [DATA_W-1:0] wb_data_i
);

    localparam int SH = $clog2(DATA_W / 8);

    bridge_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              err_q;

    logic              rvld_q;
    logic [DATA_W-1:0] rdat_q;
    logic              rerr_q;
    logic              rlast_q;

    logic              in_rd;
    logic              in_wr;
    logic              cyc;
    logic              stb;
    logic              rd_room;
    logic              resp_pop;
    logic              ack_v;
    logic              err_v;
    logic              tmo_en;
    logic              tmo_exp;
    logic              term;
    logic              is_last;
    logic [ADDR_W-1:0] beat_off;

    assign in_rd    = (state_q == ST_RD);
    assign in_wr    = (state_q == ST_WR);
    assign cyc      = in_rd || in_wr;
    assign resp_pop = rvld_q && resp_ready;
    assign rd_room  = !rvld_q || resp_ready;
    assign stb      = (in_rd && rd_room) || (in_wr && wdat_valid);
    assign ack_v    = stb && wb_ack_i && !wb_err_i;
    assign err_v    = stb && wb_err_i;
    assign tmo_en   = stb && !wb_ack_i && !wb_err_i;
    assign term     = err_v || tmo_exp;
    assign is_last  = (beat_q == len_q);
    assign beat_off = ADDR_W'(beat_q) << SH;

    urv_wb_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .en      (tmo_en),
        .clr     (!tmo_en),
        .expired (tmo_exp)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    // a terminated write beat is retired too, so the drain
    // only has to swallow the beats after it
    assign wdat_ready = (in_wr && (ack_v || term))
                     || ((state_q == ST_DRAIN) && wdat_valid);

    assign wb_cyc_o  = cyc;
    assign wb_stb_o  = stb;
    assign wb_we_o   = cyc && we_q;
    assign wb_addr_o = cyc ? addr_q + beat_off : '0;
    assign wb_data_o = in_wr ? wdat_data : '0;
    assign wb_sel_o  = in_rd ? {MASK_W{1'b1}}
                     : in_wr ? wdat_mask : '0;
    assign wb_cti_o  = cyc ? cti_sel(len_q == '0, is_last)
                           : WB_CTI_CLASSIC;
    assign wb_bte_o  = 2'b00;

    assign resp_valid = rvld_q;
    assign resp_data  = rdat_q;
    assign resp_err   = rerr_q;
    assign resp_last  = rlast_q;

    // bridge FSM plus the one-entry response register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
            rerr_q  <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            if (resp_pop)
                rvld_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        len_q   <= req_len;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= req_we ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    if (term) begin
                        err_q   <= 1'b1;
                        rvld_q  <= 1'b1;
                        rdat_q  <= '0;
                        rerr_q  <= 1'b1;
                        rlast_q <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (ack_v) begin
                        rvld_q  <= 1'b1;
                        rdat_q  <= wb_data_i;
                        rerr_q  <= 1'b0;
                        rlast_q <= is_last;
                        if (is_last)
                            state_q <= ST_RESP;
                        else
                            beat_q <= beat_q + 1'b1;
                    end
                end
                ST_WR: begin
                    if (term) begin
                        err_q <= 1'b1;
                        if (is_last) begin
                            rvld_q  <= 1'b1;
                            rdat_q  <= '0;
                            rerr_q  <= 1'b1;
                            rlast_q <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            state_q <= ST_DRAIN;
                        end
                    end else if (ack_v) begin
                        if (is_last) begin
                            rvld_q  <= 1'b1;
                            rdat_q  <= '0;
                            rerr_q  <= err_q;
                            rlast_q <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wdat_valid) begin
                        if (is_last) begin
                            rvld_q  <= 1'b1;
                            rdat_q  <= '0;
                            rerr_q  <= 1'b1;
                            rlast_q <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_pop)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urv_mem2wb_burst.sv
// Directed scoreboard bench for urv_mem2wb_burst.
// Wishbone slave model, wdat producer and response checker.
module tb_urv_mem2wb_burst;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int MB  = 8;
    localparam int LW  = 3;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [LW-1:0] req_len;
    logic          wdat_valid;
    logic          wdat_ready;
    logic [DW-1:0] wdat_data;
    logic [MW-1:0] wdat_mask;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          resp_last;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [MW-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic [DW-1:0] wb_data_i;

    int checks = 0;
    int failures = 0;
    int resp_seen = 0;
    int consumed = 0;

    urv_mem2wb_burst #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MASK_W    (MW),
        .MAX_BURST (MB),
        .LEN_W     (LW),
        .TMO_CYC   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_len    (req_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat_data  (wdat_data),
        .wdat_mask  (wdat_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_last  (resp_last),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_data_i  (wb_data_i)
    );

    always #5 clk = ~clk;

    logic [127:0] all_outs;
    assign all_outs = 128'({req_ready, wdat_ready, resp_valid,
                            resp_data, resp_err, resp_last,
                            wb_cyc_o, wb_stb_o, wb_we_o,
                            wb_addr_o, wb_data_o, wb_sel_o,
                            wb_cti_o, wb_bte_o});

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        if (a == 32'h0000_1000)
            return 32'hDEAD_BEEF;
        return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
    endfunction

    function automatic logic [2:0] exp_cti(input int b, input int len);
        if (len == 0)
            return 3'b000;
        return (b == len) ? 3'b111 : 3'b010;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- Wishbone slave model ----------------
    logic          s_mute = 1'b0;
    logic          s_err_en = 1'b0;
    logic [31:0]   s_err_addr = '0;
    logic          pend = 1'b0;

    always @(posedge clk)
        pend <= wb_stb_o && !wb_ack_i && !wb_err_i;

    assign wb_ack_i  = wb_stb_o && pend && !s_mute;
    assign wb_err_i  = wb_stb_o && pend && s_err_en
                    && (wb_addr_o == s_err_addr);
    assign wb_data_i = wb_stb_o ? rdmem(wb_addr_o) : '0;

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  cti;
        logic        we;
        logic [31:0] data;
        logic [3:0]  sel;
    } wb_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        last;
    } rsp_exp_t;

    wb_exp_t  wbq[$];
    rsp_exp_t rq[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wm_q[$];

    // response checker
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (rq.size() == 0) begin
                chk("resp_expected", 128'(rq.size() != 0), 128'd1);
            end else begin
                rsp_exp_t e;
                e = rq.pop_front();
                chk("resp_data", 128'(resp_data), 128'(e.data));
                chk("resp_err", 128'(resp_err), 128'(e.err));
                chk("resp_last", 128'(resp_last), 128'(e.last));
            end
            resp_seen++;
        end
    end

    // bus-side checker
    logic term_prev = 1'b0;
    always @(negedge clk) begin
        if (term_prev)
            chk("err_cyc_drop", 128'(wb_cyc_o), 128'd0);
        term_prev = !rst && wb_stb_o && wb_err_i;
        if (!rst && wb_cyc_o && !wb_we_o && resp_valid && !resp_ready)
            chk("rd_stall_stb", 128'(wb_stb_o), 128'd0);
        if (!rst && wb_cyc_o && wb_we_o)
            chk("wr_stb_follow", 128'(wb_stb_o), 128'(wdat_valid));
        if (!rst && wb_stb_o && (wb_ack_i || wb_err_i)) begin
            if (wbq.size() == 0) begin
                chk("wb_expected", 128'(wbq.size() != 0), 128'd1);
            end else begin
                wb_exp_t w;
                w = wbq.pop_front();
                chk("wb_addr", 128'(wb_addr_o), 128'(w.addr));
                chk("wb_cti", 128'(wb_cti_o), 128'(w.cti));
                chk("wb_we", 128'(wb_we_o), 128'(w.we));
                chk("wb_bte", 128'(wb_bte_o), 128'd0);
                if (!wb_err_i) begin
                    chk("wb_sel", 128'(wb_sel_o), 128'(w.sel));
                    if (w.we)
                        chk("wb_wdata", 128'(wb_data_o), 128'(w.data));
                end
            end
        end
    end

    // ---------------- write-data producer ----------------
    logic gaps = 1'b0;
    logic gap_tog = 1'b0;
    logic took;
    initial begin
        wdat_valid = 1'b0;
        wdat_data  = '0;
        wdat_mask  = '0;
        forever begin
            @(negedge clk);
            took = wdat_valid && wdat_ready;
            @(posedge clk);
            #1;
            if (took) begin
                wd_q.delete(0);
                wm_q.delete(0);
                consumed++;
            end
            if (took || !wdat_valid) begin
                if (gaps && gap_tog) begin
                    wdat_valid = 1'b0;
                    gap_tog    = 1'b0;
                end else if (wd_q.size() > 0) begin
                    wdat_valid = 1'b1;
                    wdat_data  = wd_q[0];
                    wdat_mask  = wm_q[0];
                    gap_tog    = 1'b1;
                end else begin
                    wdat_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_rd(input logic [31:0] base, input int len);
        for (int b = 0; b <= len; b++) begin
            logic [31:0] a;
            a = base + 32'(b * 4);
            wbq.push_back('{a, exp_cti(b, len), 1'b0, 32'h0, 4'hF});
            rq.push_back('{rdmem(a), 1'b0, b == len});
        end
    endtask

    task automatic push_wr(input logic [31:0] base, input int len,
                           input int nbus, input logic err);
        for (int b = 0; b <= len; b++) begin
            logic [31:0] d;
            logic [3:0]  m;
            d = 32'hA000_0000 + base + 32'(b);
            m = 4'(4'hF >> (b % 3)) ^ 4'(b);
            wd_q.push_back(d);
            wm_q.push_back(m);
            if (b < nbus)
                wbq.push_back('{base + 32'(b * 4), exp_cti(b, len),
                                1'b1, d, m});
        end
        rq.push_back('{32'h0, err, 1'b1});
    endtask

    task automatic do_req(input logic [31:0] a, input logic we,
                          input int len);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_len   = LW'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                chk("hs_no_cyc", 128'(wb_cyc_o), 128'd0);
                break;
            end
        end
        chk("req_accept", 128'(got), 128'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("cyc_after_hs", 128'(wb_cyc_o), 128'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rq.size() == 0 && wbq.size() == 0 && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"done_", tag}, 128'(ok), 128'd1);
    endtask

    task automatic wait_resps(input int target, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("resp_progress", 128'(ok), 128'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s0;
        int c0;
        int n;
        logic ok;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_we     = 1'b0;
        req_len    = '0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 128'(req_ready), 128'd1);

        // single-beat read
        resp_ready = 1'b1;
        push_rd(32'h1000, 0);
        do_req(32'h1000, 1'b0, 0);
        wait_done("single_rd", 50);

        // 8-beat read with a response stall after beat 2
        push_rd(32'h2000, 7);
        s0 = resp_seen;
        do_req(32'h2000, 1'b0, 7);
        wait_resps(s0 + 2, 100);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_done("burst_rd", 200);

        // 4-beat write with wdat gaps
        gaps = 1'b1;
        c0 = consumed;
        push_wr(32'h3000, 3, 4, 1'b0);
        do_req(32'h3000, 1'b1, 3);
        wait_done("burst_wr", 200);
        chk("wr_consumed", 128'(consumed - c0), 128'd4);
        gaps = 1'b0;

        // 4-beat write, error (with ack) on beat 1
        s_err_en   = 1'b1;
        s_err_addr = 32'h4004;
        c0 = consumed;
        push_wr(32'h4000, 3, 2, 1'b1);
        do_req(32'h4000, 1'b1, 3);
        wait_done("err_wr", 200);
        chk("err_consumed", 128'(consumed - c0), 128'd4);
        chk("err_wdq_empty", 128'(wd_q.size()), 128'd0);
        s_err_en = 1'b0;

        // silent slave -> timeout
        s_mute = 1'b1;
        rq.push_back('{32'h0, 1'b1, 1'b1});
        do_req(32'h5000, 1'b0, 0);
        n  = int'(wb_stb_o);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            if (wb_stb_o)
                n++;
        end
        chk("tmo_seen", 128'(ok), 128'd1);
        chk("tmo_wait", 128'(n), 128'(TMO));
        chk("tmo_cyc_drop", 128'(wb_cyc_o), 128'd0);
        wait_done("tmo", 50);
        s_mute = 1'b0;
        push_rd(32'h5008, 0);
        do_req(32'h5008, 1'b0, 0);
        wait_done("after_tmo", 50);

        // reset in the middle of a read burst
        push_rd(32'h6000, 7);
        s0 = resp_seen;
        do_req(32'h6000, 1'b0, 7);
        wait_resps(s0 + 3, 100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outs", all_outs, 128'd0);
        rq.delete();
        wbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_resp", 128'(resp_valid), 128'd0);
        chk("rst_no_cyc", 128'(wb_cyc_o), 128'd0);
        push_rd(32'h7000, 1);
        do_req(32'h7000, 1'b0, 1);
        wait_done("post_rst", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/urv_mem2wb_burst.md
Name: urv_mem2wb_burst

Overview:
- Parametrised successor to the single-beat mem-to-wishbone bridge; adds incrementing bursts on the mem side, mapped to Wishbone B4 registered-feedback cycles (CTI/BTE).
- Adds a separate write-data channel, error/timeout termination and response backpressure.
- Sits between urv_cpu sys bus (icache line refills, dcache writebacks) and the SoC Wishbone fabric; allows cfg_icache_en=1 on Wishbone systems.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (32 or 64)
- MASK_W, DATA_W/8, byte-select width
- MAX_BURST, 8, max beats per request (power of 2)
- LEN_W, $clog2(MAX_BURST), width of req_len
- TMO_CYC, 255, wait cycles without ack/err before forced error; 0 disables

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted
- req_addr  in  ADDR_W  start address, DATA_W/8-aligned
- req_we  in  1  1=write, 0=read
- req_len  in  LEN_W  beats-1
- wdat_valid  in  1  write beat valid
- wdat_ready  out  1  write beat consumed
- wdat_data  in  DATA_W  write data
- wdat_mask  in  MASK_W  byte strobes
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_data  out  DATA_W  read data (0 for writes)
- resp_err  out  1  bus error/timeout
- resp_last  out  1  final response of request
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_addr_o  out  ADDR_W  address
- wb_data_o  out  DATA_W  write data
- wb_sel_o  out  MASK_W  byte select
- wb_cti_o  out  3  cycle type
- wb_bte_o  out  2  burst type, always 2'b00 (linear)
- wb_ack_i  in  1  ack
- wb_err_i  in  1  error
- wb_data_i  in  DATA_W  read data

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter, timeout counter, response register cleared. Reset mid-burst drops cyc/stb on the next edge and discards the transaction; pending wdat beats are not consumed.
- FSM: IDLE, RD, WR, DRAIN, RESP.
- IDLE: req_ready=1. On handshake, latch addr/we/len, beat=0, go to RD or WR. No cycle starts the same cycle as req handshake; cyc/stb first assert the cycle after.
- cyc_o=1 throughout RD/WR, 0 in IDLE/DRAIN/RESP.
- cti_o: 3'b000 if len==0; 3'b010 when beat<len; 3'b111 when beat==len.
- Address: addr+beat*(DATA_W/8); wraps mod 2^ADDR_W; no boundary check.
- RD: stb=1 when the one-entry response register is empty or being popped this cycle; otherwise stb=0 (master wait state). sel=all ones. On ack: capture wb_data_i, resp_valid next cycle; resp_last=(beat==len); beat++. After last ack go to IDLE once the last response is accepted (req_ready held 0 until then).
- WR: stb=wdat_valid; data_o/sel_o=wdat_data/wdat_mask combinational; wdat_ready=wb_ack_i. wdat producer must hold beat until ready. After last ack go to RESP.
- RESP: one response, resp_last=1, resp_err=sticky err; hold until resp_ready, then IDLE.
- Error: wb_err_i, or timeout counter reaching TMO_CYC while stb=1 without ack/err, terminates burst, drops cyc next cycle.
  - Read: one response err=1, last=1, data=0; then IDLE.
  - Write: go to DRAIN; accept and discard remaining len-beat wdat beats (wdat_ready=wdat_valid); then RESP err=1.
- Timeout counter clears on every ack/err and whenever stb=0.
- ack and err both high in one cycle: err wins, beat not counted.
- Response path: single register; resp_* stable while resp_valid && !resp_ready.

Decomposition:
- urv_cfg: MAX_BURST, TMO_CYC defaults.
- urv_typedef: wb_cti_e (CLASSIC=000, INCR=010, EOB=111), bridge state enum.
- Sub-module: urv_wb_tmo (timeout counter: en, clr, expired).

Test Plan:
- Single read, req_len=0, addr 0x1000, slave acks 1 cycle later, data 0xDEADBEEF -> cti=000, one resp data 0xDEADBEEF, last=1, err=0.
- Read burst len=7 at 0x2000, resp_ready low for 3 cycles at beat 2 -> stb drops, addr 0x2000..0x201C, cti 010x7 then 111, 8 resps in order, last only on 8th.
- Write burst len=3, wdat_valid gaps -> stb follows wdat_valid, 4 acks, sel equals wdat_mask, one resp last=1 err=0.
- Write len=3, wb_err_i on beat 1 -> cyc drops, remaining 2 beats drained, one resp err=1.
- Read, slave silent, TMO_CYC=16 -> resp err=1 after 16 wait cycles, cyc drops, next request accepted.
- rst asserted mid read burst at beat 3 -> next cycle all outputs 0, no resp; new request after reset completes normally.
